// File: rtl/dist_sched_pkg.sv
// Shared types and helpers for the distance-read frame sequencer.
// Holds the FSM state encoding, modulation codes and per-modulation entry/lane tables.
package dist_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_DP = 3'd2,
    ADDR    = 3'd3,
    WAIT_RD = 3'd4,
    VALID   = 3'd5,
    DONE    = 3'd6
  } sched_state_t;

  localparam logic [1:0] M_BPSK  = 2'd0;
  localparam logic [1:0] M_QPSK  = 2'd1;
  localparam logic [1:0] M_16QAM = 2'd2;
  localparam logic [1:0] M_64QAM = 2'd3;

  // Timeout counter must hold values up to 255; latency counter up to 6.
  localparam int TMO_W = 8;
  localparam int LAT_W = 3;

  function automatic logic [4:0] entryCount(input logic [1:0] m);
    logic [4:0] n;
    case (m)
      M_BPSK:  n = 5'd1;
      M_QPSK:  n = 5'd1;
      M_16QAM: n = 5'd4;
      default: n = 5'd16;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] laneMaskOf(input logic [1:0] m);
    return (m == M_BPSK) ? 4'b0011 : 4'b1111;
  endfunction

endpackage

// File: rtl/dist_wait_cnt.sv
// Loadable up/down counter with an equality terminal flag.
// Used both as the dpDone timeout counter and as the memory read-latency counter.
module dist_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_up,
  input  logic [W-1:0] i_term_val,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= i_up ? (r_cnt + W'(1)) : (r_cnt - W'(1));
    end
  end

  assign o_term = (r_cnt == i_term_val);

endmodule

// File: rtl/dist_read_sched.sv
// Frame sequencer: starts the distance datapath, waits for it, then streams
// every stored entry's address to the sorter under a valid/ready handshake.
module dist_read_sched
  import dist_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int RD_LAT     = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frameStart,
  input  logic [1:0]            M,
  input  logic                  abort,
  output logic                  dpStart,
  output logic [1:0]            dpM,
  input  logic                  dpDone,
  output logic [ADDR_WIDTH-1:0] readAddr,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [3:0]            laneMask,
  output logic                  outLast,
  output logic                  busy,
  output logic                  frameDone,
  output logic                  errPulse,
  output sched_state_t          dbgState
);

  // Handshake: an entry transfers on a rising clk edge where outValid && outReady.
  // Once outValid rises, readAddr/laneMask/outLast hold until that transfer.

  sched_state_t          r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_readAddr, w_addr_next, w_last_addr;
  logic [1:0]            r_dpM, w_dpM_next;
  logic [3:0]            r_laneMask;
  logic                  r_dpStart, r_outValid, r_outLast, r_busy;
  logic                  r_frameDone, r_errPulse, w_err_next;
  logic                  w_tmo_term, w_lat_term;

  assign w_last_addr = ADDR_WIDTH'(entryCount(r_dpM) - 5'd1);

  dist_wait_cnt #(.W(TMO_W)) u_tmo_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == START),
    .i_load_val ('0),
    .i_en       (r_state == WAIT_DP),
    .i_up       (1'b1),
    .i_term_val (TMO_W'(TIMEOUT - 1)),
    .o_term     (w_tmo_term)
  );

  // Terminal at 1 so WAIT_RD lasts RD_LAT-1 cycles; the ADDR cycle is the first latency cycle.
  dist_wait_cnt #(.W(LAT_W)) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == ADDR),
    .i_load_val (LAT_W'(RD_LAT - 1)),
    .i_en       (r_state == WAIT_RD),
    .i_up       (1'b0),
    .i_term_val (LAT_W'(1)),
    .o_term     (w_lat_term)
  );

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_readAddr;
    w_dpM_next   = r_dpM;
    w_err_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (frameStart && !abort) begin
          w_state_next = START;
          w_dpM_next   = M;
        end
      end
      START:   w_state_next = WAIT_DP;
      WAIT_DP: begin
        if (dpDone) begin
          w_state_next = ADDR;
          w_addr_next  = '0;
        end else if (w_tmo_term) begin
          w_state_next = IDLE;
          w_err_next   = 1'b1;
        end
      end
      ADDR:    w_state_next = (RD_LAT == 1) ? VALID : WAIT_RD;
      WAIT_RD: if (w_lat_term) w_state_next = VALID;
      VALID: begin
        if (outReady) begin
          if (r_outLast) begin
            w_state_next = DONE;
          end else begin
            w_state_next = ADDR;
            w_addr_next  = r_readAddr + ADDR_WIDTH'(1);
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (r_state != IDLE && frameStart) w_err_next = 1'b1;
    // Abort silences any error from the same cycle and drops the frame.
    if (r_state != IDLE && abort) begin
      w_state_next = IDLE;
      w_err_next   = 1'b0;
    end
    if (w_state_next == IDLE || w_state_next == DONE) w_addr_next = '0;
    if (w_state_next == IDLE) w_dpM_next = '0;
  end

  // Outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_readAddr  <= '0;
      r_dpM       <= '0;
      r_dpStart   <= 1'b0;
      r_busy      <= 1'b0;
      r_outValid  <= 1'b0;
      r_outLast   <= 1'b0;
      r_laneMask  <= '0;
      r_frameDone <= 1'b0;
      r_errPulse  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_readAddr  <= w_addr_next;
      r_dpM       <= w_dpM_next;
      r_dpStart   <= (w_state_next == START);
      r_busy      <= (w_state_next != IDLE);
      r_outValid  <= (w_state_next == VALID);
      r_outLast   <= (w_state_next == VALID) && (w_addr_next == w_last_addr);
      r_laneMask  <= (w_state_next != IDLE) ? laneMaskOf(w_dpM_next) : 4'b0000;
      r_frameDone <= (w_state_next == DONE);
      r_errPulse  <= w_err_next;
    end
  end

  assign dpStart   = r_dpStart;
  assign dpM       = r_dpM;
  assign readAddr  = r_readAddr;
  assign outValid  = r_outValid;
  assign laneMask  = r_laneMask;
  assign outLast   = r_outLast;
  assign busy      = r_busy;
  assign frameDone = r_frameDone;
  assign errPulse  = r_errPulse;
  assign dbgState  = r_state;

endmodule

// File: tb/tb_dist_read_sched.sv
// Directed bench for dist_read_sched: one instance with RD_LAT=1 (a_*) and one with RD_LAT=2 (b_*).
module tb_dist_read_sched;
  import dist_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frameStart = 1'b0, abort = 1'b0, dpDone = 1'b0, outReady = 1'b0;
  logic [1:0] M = 2'd0;

  logic a_dpStart, a_outValid, a_outLast, a_busy, a_frameDone, a_errPulse;
  logic b_dpStart, b_outValid, b_outLast, b_busy, b_frameDone, b_errPulse;
  logic [1:0] a_dpM, b_dpM;
  logic [6:0] a_readAddr, b_readAddr;
  logic [3:0] a_laneMask, b_laneMask;
  sched_state_t a_dbgState, b_dbgState;
  logic [18:0] a_vec, b_vec;

  int n_vec = 0;
  int n_fail = 0;

  assign a_vec = {a_dpStart, a_dpM, a_readAddr, a_outValid, a_laneMask, a_outLast, a_busy, a_frameDone, a_errPulse};
  assign b_vec = {b_dpStart, b_dpM, b_readAddr, b_outValid, b_laneMask, b_outLast, b_busy, b_frameDone, b_errPulse};

  always #5 clk = ~clk;

  dist_read_sched #(.ADDR_WIDTH(7), .RD_LAT(1), .TIMEOUT(255)) u_dut_a (
    .clk(clk), .rst(rst), .frameStart(frameStart), .M(M), .abort(abort),
    .dpStart(a_dpStart), .dpM(a_dpM), .dpDone(dpDone), .readAddr(a_readAddr),
    .outValid(a_outValid), .outReady(outReady), .laneMask(a_laneMask), .outLast(a_outLast),
    .busy(a_busy), .frameDone(a_frameDone), .errPulse(a_errPulse), .dbgState(a_dbgState)
  );

  dist_read_sched #(.ADDR_WIDTH(7), .RD_LAT(2), .TIMEOUT(255)) u_dut_b (
    .clk(clk), .rst(rst), .frameStart(frameStart), .M(M), .abort(abort),
    .dpStart(b_dpStart), .dpM(b_dpM), .dpDone(dpDone), .readAddr(b_readAddr),
    .outValid(b_outValid), .outReady(outReady), .laneMask(b_laneMask), .outLast(b_outLast),
    .busy(b_busy), .frameDone(b_frameDone), .errPulse(b_errPulse), .dbgState(b_dbgState)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; frameStart = 1'b0; abort = 1'b0; dpDone = 1'b0; outReady = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  // Starts a frame and delivers dpDone on the first WAIT_DP cycle; both DUTs end in ADDR.
  task automatic start_frame(input string tag, input logic [1:0] m);
    M = m; frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    chk({tag, " dpStart"}, b_dpStart, 1'b1);
    chk({tag, " dpM"}, b_dpM, m);
    tick();
    dpDone = 1'b1;
    tick();
    dpDone = 1'b0;
  endtask

  // Streams a frame out of instance b, checking order, last, stability under stall and frameDone timing.
  task automatic drain_b(input string tag, input int exp_n, input logic [1:0] exp_m,
                         input logic [3:0] exp_mask, input bit toggle);
    int hs = 0;
    bit pending = 1'b0;
    bit done = 1'b0;
    bit just_last;
    logic [6:0] p_addr = '0;
    logic p_last = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      outReady = toggle ? (cyc % 2 == 0) : 1'b1;
      if (cyc == 3) M = ~exp_m;
      just_last = 1'b0;
      if (pending) begin
        chk({tag, " stall valid"}, b_outValid, 1'b1);
        chk({tag, " stall addr"}, b_readAddr, p_addr);
        chk({tag, " stall last"}, b_outLast, p_last);
      end
      if (b_outValid) begin
        if (outReady) begin
          chk({tag, " addr"}, b_readAddr, hs);
          chk({tag, " last"}, b_outLast, (hs == exp_n - 1));
          chk({tag, " mask"}, b_laneMask, exp_mask);
          chk({tag, " dpM"}, b_dpM, exp_m);
          just_last = b_outLast;
          hs++;
          pending = 1'b0;
        end else begin
          pending = 1'b1;
          p_addr = b_readAddr;
          p_last = b_outLast;
        end
      end
      tick();
      if (just_last) begin
        chk({tag, " frameDone"}, b_frameDone, 1'b1);
        chk({tag, " valid after last"}, b_outValid, 1'b0);
        done = 1'b1;
      end
    end
    outReady = 1'b0;
    chk({tag, " handshakes"}, hs, exp_n);
    chk({tag, " completed"}, done, 1'b1);
    tick();
    chk({tag, " idle"}, b_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    bit bad;
    int nv;

    // Reset state
    #1;
    chk("reset a", a_vec, 19'd0);
    chk("reset b", b_vec, 19'd0);
    chk("reset state", b_dbgState, IDLE);
    do_reset();

    // T1: QPSK, RD_LAT=1, dpDone a few cycles after dpStart
    M = M_QPSK; frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    chk("T1 dpStart", a_dpStart, 1'b1);
    chk("T1 dpM", a_dpM, M_QPSK);
    chk("T1 busy", a_busy, 1'b1);
    tick(); tick(); tick(); tick();
    chk("T1 dpStart single", a_dpStart, 1'b0);
    chk("T1 waiting", a_outValid, 1'b0);
    dpDone = 1'b1;
    tick();
    dpDone = 1'b0;
    outReady = 1'b1;
    chk("T1 addr phase valid", a_outValid, 1'b0);
    tick();
    chk("T1 valid", a_outValid, 1'b1);
    chk("T1 addr", a_readAddr, 7'd0);
    chk("T1 last", a_outLast, 1'b1);
    chk("T1 mask", a_laneMask, 4'b1111);
    tick();
    chk("T1 frameDone", a_frameDone, 1'b1);
    chk("T1 valid drop", a_outValid, 1'b0);
    tick();
    chk("T1 frameDone pulse", a_frameDone, 1'b0);
    chk("T1 idle", a_busy, 1'b0);
    outReady = 1'b0;
    do_reset();

    // T2: 64QAM, RD_LAT=2, outReady toggling, M changed mid-frame
    start_frame("T2", M_64QAM);
    drain_b("T2", 16, M_64QAM, 4'b1111, 1'b1);
    do_reset();

    // T3: dpDone never arrives
    M = M_16QAM; frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    chk("T3 dpStart", b_dpStart, 1'b1);
    tick();
    bad = 1'b0;
    for (int i = 0; i < 254; i++) begin
      tick();
      bad = bad | b_outValid | b_frameDone | b_errPulse;
    end
    chk("T3 quiet wait", bad, 1'b0);
    chk("T3 still busy", b_busy, 1'b1);
    tick();
    chk("T3 errPulse", b_errPulse, 1'b1);
    chk("T3 idle", b_busy, 1'b0);
    chk("T3 no frameDone", b_frameDone, 1'b0);
    chk("T3 no valid", b_outValid, 1'b0);
    tick();
    chk("T3 errPulse single", b_errPulse, 1'b0);

    // dpDone outside WAIT_DP is not remembered; abort in WAIT_DP
    dpDone = 1'b1;
    tick();
    dpDone = 1'b0;
    M = M_QPSK; frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    tick(); tick(); tick();
    chk("T3b still waiting", b_dbgState, WAIT_DP);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("T3b abort idle", b_busy, 1'b0);
    chk("T3b abort no err", b_errPulse, 1'b0);
    chk("T3b abort state", b_dbgState, IDLE);
    do_reset();

    // T4: frameStart during VALID of a 16QAM frame
    start_frame("T4", M_16QAM);
    for (int i = 0; i < 10 && !b_outValid; i++) tick();
    chk("T4 reached valid", b_outValid, 1'b1);
    frameStart = 1'b1; M = M_BPSK;
    tick();
    frameStart = 1'b0;
    chk("T4 errPulse", b_errPulse, 1'b1);
    chk("T4 still valid", b_outValid, 1'b1);
    chk("T4 addr held", b_readAddr, 7'd0);
    chk("T4 dpM held", b_dpM, M_16QAM);
    tick();
    chk("T4 errPulse single", b_errPulse, 1'b0);
    drain_b("T4", 4, M_16QAM, 4'b1111, 1'b0);
    do_reset();

    // T5: abort at the 3rd VALID of a 64QAM frame
    start_frame("T5", M_64QAM);
    outReady = 1'b1;
    nv = 0;
    for (int c = 0; c < 50; c++) begin
      if (b_outValid) nv++;
      if (nv == 3) break;
      tick();
    end
    chk("T5 third valid", nv, 3);
    chk("T5 third addr", b_readAddr, 7'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    outReady = 1'b0;
    chk("T5 abort outputs", b_vec, 19'd0);
    tick();
    chk("T5 no frameDone", b_frameDone, 1'b0);
    abort = 1'b1; frameStart = 1'b1;
    tick();
    abort = 1'b0; frameStart = 1'b0;
    chk("T5 abort beats start", b_busy, 1'b0);
    chk("T5 no dpStart", b_dpStart, 1'b0);
    start_frame("T5 rerun", M_QPSK);
    drain_b("T5 rerun", 1, M_QPSK, 4'b1111, 1'b0);
    do_reset();

    // T6: async reset in WAIT_RD, then a BPSK frame
    start_frame("T6", M_64QAM);
    for (int i = 0; i < 10 && b_dbgState != WAIT_RD; i++) tick();
    chk("T6 in WAIT_RD", b_dbgState, WAIT_RD);
    #2;
    rst = 1'b0;
    #1;
    chk("T6 async b", b_vec, 19'd0);
    chk("T6 async a", a_vec, 19'd0);
    chk("T6 async state", b_dbgState, IDLE);
    tick();
    rst = 1'b1;
    tick();
    start_frame("T6 bpsk", M_BPSK);
    for (int i = 0; i < 10 && !a_outValid; i++) tick();
    chk("T6 a valid", a_outValid, 1'b1);
    chk("T6 a mask", a_laneMask, 4'b0011);
    chk("T6 a last", a_outLast, 1'b1);
    drain_b("T6 bpsk", 1, M_BPSK, 4'b0011, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
